// File: rtl/cpu_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cpu_pkg
// Brief    : Shared CPU constants and the fetch-queue entry type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    // ADD R0,R0,R0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_prefetch_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : if_prefetch_if
// Brief    : Instruction-memory bus plus decode-side signals of the fetch stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface if_prefetch_if;
    import cpu_pkg::*;

    logic                imem_re;
    logic [PC_W-1:0]     imem_addr;
    logic                imem_rdy;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                alt_pc_ctrl;
    logic [PC_W-1:0]     alt_pc;
    logic                stall;
    logic                hlt;
    logic [INSTR_W-1:0]  instr;
    logic [PC_W-1:0]     pc;
    logic                instr_vld;

    modport master (
        output imem_re, imem_addr, instr, pc, instr_vld,
        input  imem_rdy, imem_rdata, alt_pc_ctrl, alt_pc, stall, hlt
    );

    modport slave (
        input  imem_re, imem_addr, instr, pc, instr_vld,
        output imem_rdy, imem_rdata, alt_pc_ctrl, alt_pc, stall, hlt
    );

endinterface
`default_nettype wire

// File: rtl/pf_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pf_fifo
// Brief    : QDEPTH-entry synchronous FIFO of {instr, pc} with flush.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pf_fifo
    import cpu_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         flush,
    input  wire logic         push,
    input  wire fetch_entry_t push_data,
    input  wire logic         pop,
    output fetch_entry_t      head,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(QDEPTH);

    fetch_entry_t      r_mem [QDEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CNT_W'(QDEPTH));
    assign w_do_pop  = pop & (r_count != '0);
    // A push into a full queue is accepted only when the head leaves this cycle.
    assign w_do_push = push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : if_prefetch
// Brief    : Instruction-fetch stage: fetch PC, memory requests, prefetch
//            queue and the IF/ID output register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module if_prefetch
    import cpu_pkg::*;
#(
    parameter int              QDEPTH   = 2,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    if_prefetch_if.master bus
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [PC_W-1:0]    r_fetch_pc;
    logic               r_halted;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;
    logic               r_instr_vld;

    logic               w_halt;
    logic               w_redirect;
    logic               w_re;
    logic               w_resp;
    logic               w_adv;
    logic               w_q_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic [PC_W-1:0]    w_next_pc;
    logic [CNT_W-1:0]   w_count;
    fetch_entry_t       w_head;
    fetch_entry_t       w_resp_entry;

    assign w_halt     = r_halted | bus.hlt;
    assign w_redirect = bus.alt_pc_ctrl & ~r_halted;
    assign w_re       = rst_n & ~w_halt & (w_count < CNT_W'(QDEPTH));
    // A response landing in a redirect cycle belongs to the abandoned path.
    assign w_resp     = w_re & bus.imem_rdy & ~w_redirect;
    assign w_adv      = ~bus.stall | ~r_instr_vld;
    assign w_q_empty  = (w_count == '0);
    assign w_next_pc  = r_fetch_pc + PC_W'(1);

    assign w_push  = w_resp & ~(w_adv & w_q_empty);
    assign w_pop   = w_adv & ~w_q_empty & ~w_redirect & ~w_halt;
    assign w_flush = w_redirect | w_halt;

    assign w_resp_entry.instr = bus.imem_rdata;
    assign w_resp_entry.pc    = w_next_pc;

    pf_fifo #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_flush),
        .push      (w_push),
        .push_data (w_resp_entry),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_halted   <= 1'b0;
        end else begin
            if (bus.hlt) r_halted <= 1'b1;
            if (w_redirect)  r_fetch_pc <= bus.alt_pc;
            else if (w_resp) r_fetch_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr     <= NOP_INSTR;
            r_pc        <= '0;
            r_instr_vld <= 1'b0;
        end else if (w_redirect) begin
            r_instr     <= NOP_INSTR;
            r_instr_vld <= 1'b0;
        end else if (w_adv) begin
            if (w_halt) begin
                r_instr     <= NOP_INSTR;
                r_instr_vld <= 1'b0;
            end else if (!w_q_empty) begin
                r_instr     <= w_head.instr;
                r_pc        <= w_head.pc;
                r_instr_vld <= 1'b1;
            end else if (w_resp) begin
                r_instr     <= bus.imem_rdata;
                r_pc        <= w_next_pc;
                r_instr_vld <= 1'b1;
            end else begin
                r_instr     <= NOP_INSTR;
                r_instr_vld <= 1'b0;
            end
        end
    end

    assign bus.imem_re   = w_re;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.instr     = r_instr;
    assign bus.pc        = r_pc;
    assign bus.instr_vld = r_instr_vld;

endmodule
`default_nettype wire
